scpad_fill_sched: RTL and testbench

Sequences DRAM-to-scratchpad row fills for the SRAM write latch. Accepts fill descriptors, splits each into 1–8 DRAM beat reads, and tags each read as {row_tag, beat[2:0]}. Holds the per-row context (spad_addr, xbar, num_request) for every in-flight row and presents it to the write latch on each DRAM response. Frees a row tag when all of its beats have returned.

---
 rtl/scpad_fill_sched.sv | 217 +++++++++++++++++++++
 tb/tb_scpad_fill_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scpad_fill_sched.sv
// rtl/scpad_fill_sched.sv - DRAM-to-scratchpad row fill scheduler with per-tag row context table.
// Optional build macro: SCPAD_FILL_PERF_EN adds request-stall and tag-full cycle counters.
module scpad_fill_sched #(
  parameter int ADDR_W      = 32,
  parameter int SPAD_ADDR_W = 10,
  parameter int XBAR_W      = 32,
  parameter int TAG_W       = 2,
  parameter int BEAT_BYTES  = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [ADDR_W-1:0]      desc_dram_addr,
  input  logic [SPAD_ADDR_W-1:0] desc_spad_addr,
  input  logic [XBAR_W-1:0]      desc_xbar,
  input  logic [2:0]             desc_num_request,
  output logic                   dram_req_valid,
  input  logic                   dram_req_ready,
  output logic [ADDR_W-1:0]      dram_req_addr,
  output logic [TAG_W+2:0]       dram_req_id,
  input  logic                   dram_res_valid,
  input  logic [TAG_W+2:0]       dram_res_id,
  output logic [SPAD_ADDR_W-1:0] lat_spad_addr,
  output logic [XBAR_W-1:0]      lat_xbar,
  output logic [2:0]             lat_num_request,
  output logic                   row_done,
  output logic [TAG_W-1:0]       row_done_tag,
  output logic                   busy,
  output logic                   err_spurious
`ifdef SCPAD_FILL_PERF_EN
  ,
  output logic [31:0]            perf_req_stall,
  output logic [31:0]            perf_tag_full
`endif
);

  localparam int NUM_ROWS = 1 << TAG_W;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [2:0]             nreq_q, nreq_d;
  logic [2:0]             beat_q, beat_d;
  logic [NUM_ROWS-1:0]    valid_q, valid_d;
  logic [SPAD_ADDR_W-1:0] spad_q [NUM_ROWS];
  logic [SPAD_ADDR_W-1:0] spad_d [NUM_ROWS];
  logic [XBAR_W-1:0]      xbar_q [NUM_ROWS];
  logic [XBAR_W-1:0]      xbar_d [NUM_ROWS];
  logic [2:0]             tnreq_q [NUM_ROWS];
  logic [2:0]             tnreq_d [NUM_ROWS];
  logic [2:0]             rcv_q [NUM_ROWS];
  logic [2:0]             rcv_d [NUM_ROWS];
  logic                   row_done_q, row_done_d;
  logic [TAG_W-1:0]       row_done_tag_q, row_done_tag_d;
  logic                   err_q, err_d;

  logic                   free_found;
  logic [TAG_W-1:0]       free_tag;
  logic [TAG_W-1:0]       res_tag;
  logic                   res_hit;
  logic                   unused_res_beat;

  assign res_tag         = dram_res_id[TAG_W+2:3];
  assign res_hit         = dram_res_valid && valid_q[res_tag];
  assign unused_res_beat = ^dram_res_id[2:0];

  // Allocation sees only registered valid bits, so a tag freed this cycle is not reused until next.
  always_comb begin
    free_found = 1'b0;
    free_tag   = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_tag   = TAG_W'(i);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    tag_d          = tag_q;
    nreq_d         = nreq_q;
    beat_d         = beat_q;
    valid_d        = valid_q;
    spad_d         = spad_q;
    xbar_d         = xbar_q;
    tnreq_d        = tnreq_q;
    rcv_d          = rcv_q;
    row_done_d     = 1'b0;
    row_done_tag_d = '0;
    err_d          = err_q;
    desc_ready     = 1'b0;
    dram_req_valid = 1'b0;
    dram_req_addr  = '0;
    dram_req_id    = '0;

    if (dram_res_valid) begin
      if (valid_q[res_tag]) begin
        rcv_d[res_tag] = rcv_q[res_tag] + 3'd1;
        if (rcv_q[res_tag] == tnreq_q[res_tag]) begin
          valid_d[res_tag] = 1'b0;
          row_done_d       = 1'b1;
          row_done_tag_d   = res_tag;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        desc_ready = desc_valid && free_found;
        if (desc_ready) begin
          valid_d[free_tag] = 1'b1;
          spad_d[free_tag]  = desc_spad_addr;
          xbar_d[free_tag]  = desc_xbar;
          tnreq_d[free_tag] = desc_num_request;
          rcv_d[free_tag]   = 3'd0;
          base_d            = desc_dram_addr;
          tag_d             = free_tag;
          nreq_d            = desc_num_request;
          beat_d            = 3'd0;
          state_d           = ISSUE;
        end
      end
      ISSUE: begin
        dram_req_valid = 1'b1;
        dram_req_addr  = base_q + ADDR_W'(beat_q) * ADDR_W'(BEAT_BYTES);
        dram_req_id    = {tag_q, beat_q};
        if (dram_req_ready) begin
          if (beat_q == nreq_q) state_d = IDLE;
          else                  beat_d  = beat_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lat_spad_addr   = '0;
    lat_xbar        = '0;
    lat_num_request = '0;
    if (res_hit) begin
      lat_spad_addr   = spad_q[res_tag];
      lat_xbar        = xbar_q[res_tag];
      lat_num_request = tnreq_q[res_tag];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      base_q         <= '0;
      tag_q          <= '0;
      nreq_q         <= '0;
      beat_q         <= '0;
      valid_q        <= '0;
      row_done_q     <= 1'b0;
      row_done_tag_q <= '0;
      err_q          <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        spad_q[i]  <= '0;
        xbar_q[i]  <= '0;
        tnreq_q[i] <= '0;
        rcv_q[i]   <= '0;
      end
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      tag_q          <= tag_d;
      nreq_q         <= nreq_d;
      beat_q         <= beat_d;
      valid_q        <= valid_d;
      row_done_q     <= row_done_d;
      row_done_tag_q <= row_done_tag_d;
      err_q          <= err_d;
      spad_q         <= spad_d;
      xbar_q         <= xbar_d;
      tnreq_q        <= tnreq_d;
      rcv_q          <= rcv_d;
    end
  end

  assign row_done     = row_done_q;
  assign row_done_tag = row_done_tag_q;
  assign err_spurious = err_q;
  assign busy         = (state_q != IDLE) || (|valid_q);

`ifdef SCPAD_FILL_PERF_EN
  logic [31:0] stall_q, stall_d, full_q, full_d;

  always_comb begin
    stall_d = stall_q;
    full_d  = full_q;
    if (dram_req_valid && !dram_req_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (desc_valid && !free_found && (full_q != '1))          full_d  = full_q + 32'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_q <= '0;
      full_q  <= '0;
    end else begin
      stall_q <= stall_d;
      full_q  <= full_d;
    end
  end

  assign perf_req_stall = stall_q;
  assign perf_tag_full  = full_q;
`endif

endmodule

// File: tb/tb_scpad_fill_sched.sv
// tb/tb_scpad_fill_sched.sv - self-checking bench for scpad_fill_sched: vector table, corner sequences, random vs row model.
module tb_scpad_fill_sched;
  localparam int NR = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        desc_valid, desc_ready;
  logic [31:0] desc_dram_addr;
  logic [9:0]  desc_spad_addr;
  logic [31:0] desc_xbar;
  logic [2:0]  desc_num_request;
  logic        dram_req_valid, dram_req_ready;
  logic [31:0] dram_req_addr;
  logic [4:0]  dram_req_id;
  logic        dram_res_valid;
  logic [4:0]  dram_res_id;
  logic [9:0]  lat_spad_addr;
  logic [31:0] lat_xbar;
  logic [2:0]  lat_num_request;
  logic        row_done;
  logic [1:0]  row_done_tag;
  logic        busy, err_spurious;
`ifdef SCPAD_FILL_PERF_EN
  logic [31:0] perf_req_stall, perf_tag_full;
`endif

  scpad_fill_sched dut (
    .clk(clk), .n_rst(n_rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_dram_addr(desc_dram_addr),
    .desc_spad_addr(desc_spad_addr), .desc_xbar(desc_xbar), .desc_num_request(desc_num_request),
    .dram_req_valid(dram_req_valid), .dram_req_ready(dram_req_ready),
    .dram_req_addr(dram_req_addr), .dram_req_id(dram_req_id),
    .dram_res_valid(dram_res_valid), .dram_res_id(dram_res_id),
    .lat_spad_addr(lat_spad_addr), .lat_xbar(lat_xbar), .lat_num_request(lat_num_request),
    .row_done(row_done), .row_done_tag(row_done_tag), .busy(busy), .err_spurious(err_spurious)
`ifdef SCPAD_FILL_PERF_EN
    , .perf_req_stall(perf_req_stall), .perf_tag_full(perf_tag_full)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  id;
  } req_t;

  // Row model: one record per tag plus the list of beat reads still owed by the current descriptor.
  bit          m_valid [NR];
  logic [9:0]  m_spad [NR];
  logic [31:0] m_xbar [NR];
  int          m_nreq [NR];
  int          m_rcv [NR];
  req_t        m_reqq [$];
  logic [4:0]  m_out [$];
  logic        m_err;
  logic        last_acc;
  logic [1:0]  last_tag;

  logic        cap_dr, cap_qv, cap_busy, cap_done, cap_err;
  logic [31:0] cap_addr, cap_lx;
  logic [4:0]  cap_id;
  logic [9:0]  cap_ls;
  logic [2:0]  cap_ln;
  logic [1:0]  cap_dtag;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_valid[i] = 0; m_spad[i] = '0; m_xbar[i] = '0; m_nreq[i] = 0; m_rcv[i] = 0;
    end
    m_reqq.delete();
    m_out.delete();
    m_err = 1'b0;
  endtask

  task automatic set_idle();
    desc_valid = 0; desc_dram_addr = '0; desc_spad_addr = '0; desc_xbar = '0; desc_num_request = '0;
    dram_req_ready = 1; dram_res_valid = 0; dram_res_id = '0;
  endtask

  // One clock: sample combinational outputs at negedge, advance model, sample registered outputs after posedge.
  task automatic tick();
    logic       ex_dr, ex_qv, ex_busy, fnd, ex_done;
    logic [1:0] ftag, ex_dtag;
    int         rt;
    logic [9:0] ex_ls;
    logic [31:0] ex_lx;
    logic [2:0] ex_ln;
    @(negedge clk);
    cap_dr = desc_ready; cap_qv = dram_req_valid; cap_addr = dram_req_addr; cap_id = dram_req_id;
    cap_ls = lat_spad_addr; cap_lx = lat_xbar; cap_ln = lat_num_request; cap_busy = busy;

    fnd = 0; ftag = 0;
    for (int i = 0; i < NR; i++) if (!fnd && !m_valid[i]) begin fnd = 1; ftag = 2'(i); end
    ex_dr = desc_valid && (m_reqq.size() == 0) && fnd;
    ex_qv = (m_reqq.size() != 0);
    ex_busy = ex_qv;
    for (int i = 0; i < NR; i++) if (m_valid[i]) ex_busy = 1;
    rt = int'(dram_res_id[4:3]);
    ex_ls = '0; ex_lx = '0; ex_ln = '0;
    if (dram_res_valid && m_valid[rt]) begin
      ex_ls = m_spad[rt]; ex_lx = m_xbar[rt]; ex_ln = 3'(m_nreq[rt]);
    end

    chk("desc_ready", cap_dr, ex_dr);
    chk("req_valid", cap_qv, ex_qv);
    if (ex_qv) begin
      chk("req_addr", cap_addr, m_reqq[0].addr);
      chk("req_id", cap_id, m_reqq[0].id);
    end
    chk("lat_spad", cap_ls, ex_ls);
    chk("lat_xbar", cap_lx, ex_lx);
    chk("lat_nreq", cap_ln, ex_ln);
    chk("busy", cap_busy, ex_busy);

    ex_done = 0; ex_dtag = 0;
    if (dram_res_valid) begin
      if (m_valid[rt]) begin
        if (m_rcv[rt] == m_nreq[rt]) begin
          m_valid[rt] = 0; ex_done = 1; ex_dtag = 2'(rt);
        end
        m_rcv[rt]++;
        for (int i = 0; i < m_out.size(); i++)
          if (m_out[i] == dram_res_id) begin m_out.delete(i); break; end
      end else begin
        m_err = 1'b1;
      end
    end
    if (ex_qv && dram_req_ready) begin
      m_out.push_back(m_reqq[0].id);
      void'(m_reqq.pop_front());
    end
    last_acc = ex_dr;
    if (ex_dr) begin
      req_t r;
      m_valid[ftag] = 1; m_spad[ftag] = desc_spad_addr; m_xbar[ftag] = desc_xbar;
      m_nreq[ftag] = int'(desc_num_request); m_rcv[ftag] = 0;
      last_tag = ftag;
      for (int b = 0; b <= int'(desc_num_request); b++) begin
        r.addr = desc_dram_addr + 32'(b * 8);
        r.id   = {ftag, 3'(b)};
        m_reqq.push_back(r);
      end
    end

    @(posedge clk); #1;
    cap_done = row_done; cap_dtag = row_done_tag; cap_err = err_spurious;
    chk("row_done", cap_done, ex_done);
    chk("row_done_tag", cap_dtag, ex_dtag);
    chk("err_spurious", cap_err, m_err);
  endtask

  task automatic send_desc(input logic [31:0] a, input logic [9:0] s, input logic [31:0] x, input logic [2:0] n);
    desc_valid = 1; desc_dram_addr = a; desc_spad_addr = s; desc_xbar = x; desc_num_request = n;
    last_acc = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (last_acc) break;
    end
    chk("desc_accept_bound", last_acc, 1);
    desc_valid = 0;
  endtask

  task automatic wait_issue_done();
    dram_req_ready = 1;
    for (int k = 0; k < 50; k++) begin
      if (m_reqq.size() == 0) break;
      tick();
    end
    chk("issue_drain_bound", m_reqq.size() == 0, 1);
  endtask

  task automatic respond(input logic [4:0] id);
    dram_res_valid = 1; dram_res_id = id;
    tick();
    dram_res_valid = 0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_desc_ready"}, desc_ready, 0);
    chk({nm, "_req_valid"}, dram_req_valid, 0);
    chk({nm, "_req_addr"}, dram_req_addr, 0);
    chk({nm, "_req_id"}, dram_req_id, 0);
    chk({nm, "_lat_spad"}, lat_spad_addr, 0);
    chk({nm, "_lat_xbar"}, lat_xbar, 0);
    chk({nm, "_lat_nreq"}, lat_num_request, 0);
    chk({nm, "_row_done"}, row_done, 0);
    chk({nm, "_row_done_tag"}, row_done_tag, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err_spurious, 0);
  endtask

  typedef struct {
    logic dv; logic rdy; logic rv; logic [4:0] rid;
    logic e_dr; logic e_qv; logic [31:0] e_addr; logic [4:0] e_id; logic [9:0] e_ls; logic e_busy; logic e_done;
  } vec_t;
  vec_t tv [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int ord [8];
    ord = '{5, 2, 7, 0, 1, 3, 4, 6};
    // Single row: 0x1000, 4 beats, tag 0, ready held high.
    tv[0] = '{1'b1, 1'b1, 1'b0, 5'h00, 1'b1, 1'b0, 32'h0,    5'h00, 10'h000, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h1000, 5'h00, 10'h000, 1'b1, 1'b0};
    tv[2] = '{1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h1008, 5'h01, 10'h000, 1'b1, 1'b0};
    tv[3] = '{1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h1010, 5'h02, 10'h000, 1'b1, 1'b0};
    tv[4] = '{1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h1018, 5'h03, 10'h000, 1'b1, 1'b0};
    tv[5] = '{1'b0, 1'b1, 1'b1, 5'h00, 1'b0, 1'b0, 32'h0,    5'h00, 10'h055, 1'b1, 1'b0};
    tv[6] = '{1'b0, 1'b1, 1'b1, 5'h01, 1'b0, 1'b0, 32'h0,    5'h00, 10'h055, 1'b1, 1'b0};
    tv[7] = '{1'b0, 1'b1, 1'b1, 5'h02, 1'b0, 1'b0, 32'h0,    5'h00, 10'h055, 1'b1, 1'b0};
    tv[8] = '{1'b0, 1'b1, 1'b1, 5'h03, 1'b0, 1'b0, 32'h0,    5'h00, 10'h055, 1'b1, 1'b1};
    tv[9] = '{1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 32'h0,    5'h00, 10'h000, 1'b0, 1'b0};

    n_rst = 0;
    set_idle();
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk); n_rst = 1;
    @(posedge clk); #1;

    desc_dram_addr = 32'h1000; desc_spad_addr = 10'h055; desc_xbar = 32'hA5A5_0001; desc_num_request = 3'd3;
    for (int i = 0; i < 10; i++) begin
      desc_valid = tv[i].dv; dram_req_ready = tv[i].rdy; dram_res_valid = tv[i].rv; dram_res_id = tv[i].rid;
      tick();
      chk("tv_desc_ready", cap_dr, tv[i].e_dr);
      chk("tv_req_valid", cap_qv, tv[i].e_qv);
      if (tv[i].e_qv) begin
        chk("tv_req_addr", cap_addr, tv[i].e_addr);
        chk("tv_req_id", cap_id, tv[i].e_id);
      end
      chk("tv_lat_spad", cap_ls, tv[i].e_ls);
      chk("tv_busy", cap_busy, tv[i].e_busy);
      chk("tv_row_done", cap_done, tv[i].e_done);
      if (tv[i].e_done) chk("tv_row_done_tag", cap_dtag, 0);
    end
    set_idle();

    // Backpressure at beat 2.
    send_desc(32'h2000, 10'h101, 32'hB0B0_0002, 3'd4);
    tick(); tick();
    dram_req_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_addr", cap_addr, 32'h2010);
      chk("bp_hold_id", cap_id, 5'h02);
    end
    dram_req_ready = 1;
    for (int b = 2; b <= 4; b++) begin
      tick();
      chk("bp_resume_id", cap_id, 5'(b));
      chk("bp_resume_addr", cap_addr, 32'h2000 + 32'(b * 8));
    end
    tick();
    chk("bp_no_extra_req", cap_qv, 0);
    for (int b = 0; b <= 4; b++) respond(5'(b));

    // Out-of-order returns for tag 1.
    send_desc(32'h3000, 10'h0AA, 32'h0000_0011, 3'd0);
    wait_issue_done();
    send_desc(32'h4000, 10'h1BC, 32'hCAFE_F00D, 3'd7);
    chk("ooo_tag", last_tag, 2'd1);
    wait_issue_done();
    for (int k = 0; k < 8; k++) begin
      respond(5'(8 + ord[k]));
      chk("ooo_lat_spad", cap_ls, 10'h1BC);
      chk("ooo_lat_xbar", cap_lx, 32'hCAFE_F00D);
      chk("ooo_row_done", cap_done, k == 7);
    end
    chk("ooo_done_tag", cap_dtag, 2'd1);
    respond(5'h00);

    // Full table; freeing tag 2 lets the waiting descriptor in one cycle later.
    for (int i = 0; i < 4; i++) begin
      send_desc(32'h5000 + 32'(i * 256), 10'(i), 32'(i), 3'd0);
      wait_issue_done();
    end
    desc_valid = 1; desc_dram_addr = 32'h6000; desc_spad_addr = 10'h3FF; desc_xbar = 32'h55; desc_num_request = 3'd0;
    tick();
    chk("full_ready_low", cap_dr, 0);
    dram_res_valid = 1; dram_res_id = 5'h10;
    tick();
    chk("full_ready_same_cycle", cap_dr, 0);
    dram_res_valid = 0;
    tick();
    chk("full_ready_after_free", cap_dr, 1);
    desc_valid = 0;
    tick();
    chk("full_realloc_id", cap_id, 5'h10);
    chk("full_realloc_addr", cap_addr, 32'h6000);
    respond(5'h00); respond(5'h08); respond(5'h18); respond(5'h10);

    // Address wrap, then a response to an unallocated tag.
    send_desc(32'hFFFF_FFF8, 10'h002, 32'h3, 3'd1);
    tick();
    chk("wrap_addr0", cap_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap_addr1", cap_addr, 32'h0000_0000);
    chk("wrap_id1", cap_id, 5'h01);
    respond(5'h18);
    chk("spur_lat_spad", cap_ls, 0);
    chk("spur_lat_xbar", cap_lx, 0);
    chk("spur_err", cap_err, 1);
    respond(5'h00); respond(5'h01);
    chk("spur_table_intact", cap_done, 1);

    // Reset during beat 4 of an 8-beat row.
    send_desc(32'h7000, 10'h003, 32'h4, 3'd7);
    for (int k = 0; k < 4; k++) tick();
    chk("pre_reset_id", dram_req_id, 5'h04);
    n_rst = 0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk); n_rst = 1;
    @(posedge clk); #1;
    respond(5'h00);
    chk("post_reset_spur_err", cap_err, 1);
    chk("post_reset_lat", cap_ls, 0);

    // Random traffic against the row model.
    for (int c = 0; c < 4000; c++) begin
      desc_valid = ($urandom_range(0, 2) == 0);
      desc_dram_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 31))) : $urandom;
      desc_spad_addr = 10'($urandom_range(0, 1023));
      desc_xbar = $urandom;
      desc_num_request = 3'($urandom_range(0, 7));
      dram_req_ready = ($urandom_range(0, 3) != 0);
      dram_res_valid = 0;
      if (m_out.size() != 0 && $urandom_range(0, 1) == 1) begin
        dram_res_valid = 1;
        dram_res_id = m_out[$urandom_range(0, m_out.size() - 1)];
      end else if ($urandom_range(0, 19) == 0) begin
        for (int t = 0; t < NR; t++) if (!m_valid[t] && !dram_res_valid) begin
          dram_res_valid = 1;
          dram_res_id = {2'(t), 3'($urandom_range(0, 7))};
        end
      end
      tick();
    end
    set_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
